// File: rtl/cmt_sumcheck_sequencer_if.sv
// Prover / entropy / oracle bus of the CMT sumcheck sequencer.
// The master side is the sequencer; the slave side is the environment.
interface cmt_sumcheck_sequencer_if #(
    parameter int UINT_WIDTH = 32,
    parameter int NUM_LAYERS = 4,
    parameter int NUM_BITS   = NUM_LAYERS - 1,
    parameter int LW         = $clog2(NUM_LAYERS + 1)
);
    logic                    rand_bit;
    logic                    rand_valid;
    logic                    rand_ready;
    logic                    poly_valid;
    logic                    poly_ready;
    logic [UINT_WIDTH-1:0]   poly_pt0;
    logic [UINT_WIDTH-1:0]   poly_pt1;
    logic                    qry_valid;
    logic                    qry_ready;
    logic                    qry_final;
    logic [LW-1:0]           qry_layer;
    logic [NUM_BITS-1:0]     qry_gate;
    logic [2*NUM_BITS-1:0]   qry_lbl;
    logic [UINT_WIDTH-1:0]   qry_claim;
    logic                    qry_is_add;
    logic                    qry_ok;
    logic [UINT_WIDTH-1:0]   qry_v0;
    logic [UINT_WIDTH-1:0]   qry_v1;

    modport master (
        output rand_ready, poly_ready, qry_valid, qry_final, qry_layer, qry_gate, qry_lbl,
        input  rand_bit, rand_valid, poly_valid, poly_pt0, poly_pt1,
        input  qry_ready, qry_claim, qry_is_add, qry_ok, qry_v0, qry_v1
    );

    modport slave (
        input  rand_ready, poly_ready, qry_valid, qry_final, qry_layer, qry_gate, qry_lbl,
        output rand_bit, rand_valid, poly_valid, poly_pt0, poly_pt1,
        output qry_ready, qry_claim, qry_is_add, qry_ok, qry_v0, qry_v1
    );
endinterface

// File: rtl/cmt_sumcheck_sequencer.sv
// CMT verifier top-level sequencer: runs one sumcheck instance per circuit
// layer, drawing challenges from the entropy pin, checking the prover's round
// polynomials and querying the wiring/value oracle for claims and gate checks.
module cmt_sumcheck_sequencer #(
    parameter int UINT_WIDTH = 32,
    parameter int NUM_LAYERS = 4,
    parameter int NUM_BITS   = NUM_LAYERS - 1,
    parameter int LW         = $clog2(NUM_LAYERS + 1),
    parameter int RW         = $clog2(2 * NUM_BITS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    cmt_sumcheck_sequencer_if.master    bus,
    output logic                        busy,
    output logic                        done,
    output logic                        accept,
    output logic [LW-1:0]               layer,
    output logic [RW-1:0]               round
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEED  = 3'd1;
    localparam logic [2:0] S_CLAIM = 3'd2;
    localparam logic [2:0] S_POLY  = 3'd3;
    localparam logic [2:0] S_CHAL  = 3'd4;
    localparam logic [2:0] S_FINAL = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [RW-1:0] LAST_ROUND = RW'(2 * NUM_BITS - 1);
    localparam logic [RW-1:0] SEED_LAST  = RW'(NUM_BITS - 1);
    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

    logic [2:0]              state_r;
    logic [2:0]              state_nxt_s;
    logic [RW-1:0]           seed_cnt_r;
    logic [RW-1:0]           round_r;
    logic [LW-1:0]           layer_r;
    logic [NUM_BITS-1:0]     gate_r;
    logic [2*NUM_BITS-1:0]   lbl_r;
    logic [UINT_WIDTH-1:0]   claim_r;
    logic [UINT_WIDTH-1:0]   e_r;
    logic [UINT_WIDTH-1:0]   pt0_r;
    logic [UINT_WIDTH-1:0]   pt1_r;
    logic                    rand_ready_r;
    logic                    poly_ready_r;
    logic                    qry_valid_r;
    logic                    qry_final_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    accept_r;

    logic                    rand_fire_s;
    logic                    poly_fire_s;
    logic                    qry_fire_s;
    logic [UINT_WIDTH-1:0]   poly_sum_s;
    logic [UINT_WIDTH-1:0]   ref_s;
    logic                    poly_bad_s;
    logic [UINT_WIDTH-1:0]   prod_s;
    logic [UINT_WIDTH-1:0]   gate_val_s;
    logic                    final_bad_s;

    // Transfers complete only when the matching ready/valid pair is high.
    assign rand_fire_s = bus.rand_valid & rand_ready_r;
    assign poly_fire_s = bus.poly_valid & poly_ready_r;
    assign qry_fire_s  = bus.qry_ready & qry_valid_r;

    // Round-0 polynomial is checked against the oracle claim, later rounds
    // against the previous round's polynomial evaluated at its challenge.
    assign poly_sum_s  = bus.poly_pt0 + bus.poly_pt1;
    assign ref_s       = (round_r == {RW{1'b0}}) ? claim_r : e_r;
    assign poly_bad_s  = (poly_sum_s != ref_s);
    assign prod_s      = bus.qry_v0 * bus.qry_v1;
    assign gate_val_s  = !bus.qry_ok     ? {UINT_WIDTH{1'b0}} :
                         bus.qry_is_add  ? (bus.qry_v0 + bus.qry_v1) : prod_s;
    assign final_bad_s = (gate_val_s != e_r);

    assign bus.rand_ready = rand_ready_r;
    assign bus.poly_ready = poly_ready_r;
    assign bus.qry_valid  = qry_valid_r;
    assign bus.qry_final  = qry_final_r;
    assign bus.qry_layer  = layer_r;
    assign bus.qry_gate   = gate_r;
    assign bus.qry_lbl    = lbl_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign accept         = accept_r;
    assign layer          = layer_r;
    assign round          = round_r;

    // Next-state selection for the sequencing FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) state_nxt_s = S_SEED;
                else       state_nxt_s = state_r;
            end
            S_SEED: begin
                if (rand_fire_s && (seed_cnt_r == SEED_LAST)) state_nxt_s = S_CLAIM;
                else                                          state_nxt_s = S_SEED;
            end
            S_CLAIM: begin
                if (qry_fire_s) state_nxt_s = S_POLY;
                else            state_nxt_s = S_CLAIM;
            end
            S_POLY: begin
                if (poly_fire_s) state_nxt_s = poly_bad_s ? S_DONE : S_CHAL;
                else             state_nxt_s = S_POLY;
            end
            S_CHAL: begin
                if (rand_fire_s) state_nxt_s = (round_r == LAST_ROUND) ? S_FINAL : S_POLY;
                else             state_nxt_s = S_CHAL;
            end
            S_FINAL: begin
                if (qry_fire_s) state_nxt_s = (final_bad_s || (layer_r == LAST_LAYER)) ? S_DONE : S_POLY;
                else            state_nxt_s = S_FINAL;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, handshake flags (registered from next state) and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            seed_cnt_r   <= {RW{1'b0}};
            round_r      <= {RW{1'b0}};
            layer_r      <= {LW{1'b0}};
            gate_r       <= {NUM_BITS{1'b0}};
            lbl_r        <= {(2*NUM_BITS){1'b0}};
            claim_r      <= {UINT_WIDTH{1'b0}};
            e_r          <= {UINT_WIDTH{1'b0}};
            pt0_r        <= {UINT_WIDTH{1'b0}};
            pt1_r        <= {UINT_WIDTH{1'b0}};
            rand_ready_r <= 1'b0;
            poly_ready_r <= 1'b0;
            qry_valid_r  <= 1'b0;
            qry_final_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            accept_r     <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            rand_ready_r <= (state_nxt_s == S_SEED) || (state_nxt_s == S_CHAL);
            poly_ready_r <= (state_nxt_s == S_POLY);
            qry_valid_r  <= (state_nxt_s == S_CLAIM) || (state_nxt_s == S_FINAL);
            qry_final_r  <= (state_nxt_s == S_FINAL);
            busy_r       <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        layer_r    <= {LW{1'b0}};
                        round_r    <= {RW{1'b0}};
                        gate_r     <= {NUM_BITS{1'b0}};
                        seed_cnt_r <= {RW{1'b0}};
                        done_r     <= 1'b0;
                        accept_r   <= 1'b1;
                    end
                end
                S_SEED: begin
                    if (rand_fire_s) begin
                        gate_r     <= NUM_BITS'({gate_r, bus.rand_bit});
                        seed_cnt_r <= seed_cnt_r + RW'(1);
                    end
                end
                S_CLAIM: begin
                    if (qry_fire_s) claim_r <= bus.qry_claim;
                end
                S_POLY: begin
                    if (poly_fire_s) begin
                        if (poly_bad_s) begin
                            accept_r <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            pt0_r <= bus.poly_pt0;
                            pt1_r <= bus.poly_pt1;
                        end
                    end
                end
                S_CHAL: begin
                    if (rand_fire_s) begin
                        for (int i = 0; i < 2 * NUM_BITS; i++) begin
                            if (round_r == RW'(i)) lbl_r[i] <= bus.rand_bit;
                        end
                        e_r     <= bus.rand_bit ? pt1_r : pt0_r;
                        round_r <= round_r + RW'(1);
                    end
                end
                S_FINAL: begin
                    if (qry_fire_s) begin
                        if (final_bad_s) begin
                            accept_r <= 1'b0;
                            done_r   <= 1'b1;
                        end else if (layer_r == LAST_LAYER) begin
                            done_r <= 1'b1;
                        end else begin
                            claim_r <= bus.qry_v0;
                            gate_r  <= lbl_r[NUM_BITS-1:0];
                            layer_r <= layer_r + LW'(1);
                            round_r <= {RW{1'b0}};
                            lbl_r   <= {(2*NUM_BITS){1'b0}};
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cmt_sumcheck_sequencer.sv
// Self-checking bench for cmt_sumcheck_sequencer: the bench plays prover,
// entropy source and oracle, and predicts the verdict from the sumcheck rules.
module tb_cmt_sumcheck_sequencer;
    localparam int W  = 32;
    localparam int NL = 2;
    localparam int NB = 1;
    localparam int LW = $clog2(NL + 1);
    localparam int RW = $clog2(2 * NB + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, accept;
    logic [LW-1:0] layer;
    logic [RW-1:0] round;

    int checks = 0;
    int failures = 0;
    bit aborted = 1'b0;
    bit aborted_run = 1'b0;
    bit bits_q[$];

    int stall_cyc;
    int cfg_kind[NL];
    int cfg_force_e[NL];
    int cfg_bad_layer, cfg_bad_round, cfg_abort_layer;
    bit cfg_t2;

    cmt_sumcheck_sequencer_if #(.UINT_WIDTH(W), .NUM_LAYERS(NL), .NUM_BITS(NB), .LW(LW)) bus ();

    cmt_sumcheck_sequencer #(.UINT_WIDTH(W), .NUM_LAYERS(NL), .NUM_BITS(NB), .LW(LW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .accept(accept), .layer(layer), .round(round)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int k);
        case (k)
            0:       return bus.rand_ready;
            1:       return bus.poly_ready;
            default: return bus.qry_valid;
        endcase
    endfunction

    function automatic logic [31:0] obs_snap();
        return 32'({layer, round, busy, done, accept, bus.rand_ready, bus.poly_ready,
                    bus.qry_valid, bus.qry_final, bus.qry_layer, bus.qry_gate, bus.qry_lbl});
    endfunction

    function automatic bit next_bit();
        if (bits_q.size() > 0) return bits_q.pop_front();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cfg_default();
        stall_cyc = 0; cfg_t2 = 1'b0;
        cfg_bad_layer = -1; cfg_bad_round = -1; cfg_abort_layer = -1;
        for (int i = 0; i < NL; i++) begin cfg_kind[i] = 0; cfg_force_e[i] = -1; end
    endtask

    // Wait (bounded) at negedges until the requested handshake is offered.
    task automatic wait_rdy(input int k, input string tag);
        int n;
        n = 0;
        if (aborted) return;
        @(negedge clk);
        while (!rdy(k) && n < 300) begin @(negedge clk); n++; end
        chk({"wait_", tag}, rdy(k), 1'b1);
        if (!rdy(k)) aborted = 1'b1;
        else chk({"one_req_", tag}, 64'(bus.rand_ready) + 64'(bus.poly_ready) + 64'(bus.qry_valid), 1);
    endtask

    // Optional stall inside a wait state: outputs must not move; stray rand bits offered.
    task automatic stall_here(input int k);
        logic [31:0] s0;
        if (aborted || stall_cyc == 0) return;
        s0 = obs_snap();
        if (k != 0) begin bus.rand_bit = 1'b1; bus.rand_valid = 1'b1; end
        repeat (stall_cyc) @(negedge clk);
        bus.rand_valid = 1'b0;
        chk("stall_stable", obs_snap(), s0);
    endtask

    task automatic send_rand(input bit b);
        wait_rdy(0, "rand"); stall_here(0);
        if (aborted) return;
        bus.rand_bit = b; bus.rand_valid = 1'b1;
        @(posedge clk); #1 bus.rand_valid = 1'b0;
    endtask

    task automatic send_poly(input logic [W-1:0] p0, input logic [W-1:0] p1, input int r);
        wait_rdy(1, "poly");
        if (aborted) return;
        chk("poly_round", round, r);
        stall_here(1);
        bus.poly_pt0 = p0; bus.poly_pt1 = p1; bus.poly_valid = 1'b1;
        @(posedge clk); #1 bus.poly_valid = 1'b0;
    endtask

    task automatic serve_qry(input bit fin, input logic [W-1:0] claim, input bit add, input bit ok,
                             input logic [W-1:0] v0, input logic [W-1:0] v1,
                             input logic [NB-1:0] g, input logic [2*NB-1:0] lbl, input int l);
        wait_rdy(2, fin ? "final" : "claim");
        if (aborted) return;
        chk("qry_final", bus.qry_final, fin);
        chk("qry_layer", bus.qry_layer, l);
        chk("qry_gate", bus.qry_gate, g);
        if (fin) begin
            chk("qry_lbl", bus.qry_lbl, lbl);
            chk("final_round", round, 2 * NB);
        end
        stall_here(2);
        bus.qry_claim = claim; bus.qry_is_add = add; bus.qry_ok = ok;
        bus.qry_v0 = v0; bus.qry_v1 = v1; bus.qry_ready = 1'b1;
        @(posedge clk); #1 bus.qry_ready = 1'b0;
    endtask

    // Plays one proof according to the cfg_* knobs and predicts the verdict.
    task automatic run_proof(output bit exp_acc);
        logic [W-1:0] claim, refv, p0, p1, e, v0, v1, a, fv;
        logic [NB-1:0] g;
        logic [2*NB-1:0] lbl;
        bit b, ok, add;
        exp_acc = 1'b1; aborted_run = 1'b0; e = '0;
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        g = '0;
        for (int i = 0; i < NB; i++) begin b = next_bit(); send_rand(b); g = NB'({g, b}); end
        claim = cfg_t2 ? 32'd10 : $urandom;
        serve_qry(1'b0, claim, 1'b0, 1'b0, 32'd0, 32'd0, g, '0, 0);
        for (int l = 0; l < NL; l++) begin
            lbl = '0;
            for (int r = 0; r < 2 * NB; r++) begin
                if (aborted) return;
                refv = (r == 0) ? claim : e;
                b = next_bit();
                p0 = $urandom; p1 = refv - p0;
                if (r == 2 * NB - 1 && cfg_force_e[l] >= 0) begin
                    fv = W'(cfg_force_e[l]);
                    if (b) begin p1 = fv; p0 = refv - fv; end
                    else   begin p0 = fv; p1 = refv - fv; end
                end
                if (cfg_t2 && l == 0 && r == 0) begin p0 = 32'd4; p1 = 32'd5; end
                if (l == cfg_bad_layer && r == cfg_bad_round) p1 = p1 + 32'd1 + W'($urandom_range(0, 99));
                send_poly(p0, p1, r);
                if (W'(p0 + p1) != refv) begin exp_acc = 1'b0; return; end
                if (l == cfg_abort_layer) begin aborted_run = 1'b1; return; end
                send_rand(b);
                lbl[r] = b;
                e = b ? p1 : p0;
            end
            ok = 1'b1; add = 1'b1; v0 = $urandom; v1 = e - v0;
            case (cfg_kind[l])
                1:       begin add = 1'b0; v0 = 32'h0001_0000; v1 = 32'h0001_0000; end
                2:       ok = 1'b0;
                3:       v1 = v1 + 32'd1 + W'($urandom_range(0, 99));
                default: ;
            endcase
            a = !ok ? 32'd0 : (add ? W'(v0 + v1) : W'(v0 * v1));
            serve_qry(1'b1, 32'd0, add, ok, v0, v1, g, lbl, l);
            if (a != e) begin exp_acc = 1'b0; return; end
            claim = v0;
            g = lbl[NB-1:0];
        end
    endtask

    task automatic check_end(input bit exp_acc, input string tag);
        logic any_req;
        any_req = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_accept"}, accept, exp_acc);
        chk({tag, "_busy"}, busy, 1'b0);
        repeat (10) begin
            @(negedge clk);
            any_req = any_req | bus.rand_ready | bus.poly_ready | bus.qry_valid;
        end
        chk({tag, "_no_req"}, any_req, 1'b0);
        chk({tag, "_done_held"}, done, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rand_ready"}, bus.rand_ready, 1'b0);
        chk({tag, "_poly_ready"}, bus.poly_ready, 1'b0);
        chk({tag, "_qry_valid"}, bus.qry_valid, 1'b0);
        chk({tag, "_qry_final"}, bus.qry_final, 1'b0);
        chk({tag, "_qry_gate"}, bus.qry_gate, 0);
        chk({tag, "_qry_lbl"}, bus.qry_lbl, 0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_accept"}, accept, 1'b1);
        chk({tag, "_layer"}, layer, 0);
        chk({tag, "_round"}, round, 0);
    endtask

    initial begin
        bit ea;
        bus.rand_bit = 1'b0; bus.rand_valid = 1'b0; bus.poly_valid = 1'b0;
        bus.poly_pt0 = '0; bus.poly_pt1 = '0; bus.qry_ready = 1'b0; bus.qry_claim = '0;
        bus.qry_is_add = 1'b0; bus.qry_ok = 1'b0; bus.qry_v0 = '0; bus.qry_v1 = '0;
        cfg_default();
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset("idle");

        // Honest prover with the listed entropy bits.
        bits_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        run_proof(ea); check_end(ea, "honest");
        chk("honest_model", ea, 1'b1);

        // Same proof with 20-cycle stalls in every wait state.
        cfg_default(); stall_cyc = 20;
        bits_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        run_proof(ea); check_end(ea, "stalled");

        // Round-0 sum 4+5 against claim 10.
        cfg_default(); cfg_t2 = 1'b1;
        run_proof(ea); check_end(ea, "bad_round0");

        // Wiring predicate false: passes only when e is 0.
        cfg_default(); cfg_kind[NL-1] = 2; cfg_force_e[NL-1] = 0;
        run_proof(ea); check_end(ea, "ok0_e0");
        cfg_default(); cfg_kind[NL-1] = 2; cfg_force_e[NL-1] = 7;
        run_proof(ea); check_end(ea, "ok0_e7");

        // MUL gate whose product wraps to zero, on both layers.
        cfg_default(); cfg_kind[0] = 1; cfg_force_e[0] = 0; cfg_kind[NL-1] = 1; cfg_force_e[NL-1] = 0;
        run_proof(ea); check_end(ea, "mul_wrap");

        // Wrong gate values from the oracle on layer 0.
        cfg_default(); cfg_kind[0] = 3;
        run_proof(ea); check_end(ea, "bad_final");

        // Bad polynomial in a later round of the last layer.
        cfg_default(); cfg_bad_layer = NL - 1; cfg_bad_round = 2 * NB - 1;
        run_proof(ea); check_end(ea, "bad_late_poly");

        // Reset during layer-1 challenge, then a full honest run.
        cfg_default(); cfg_abort_layer = 1;
        run_proof(ea);
        chk("abort_reached", aborted_run, 1'b1);
        @(negedge clk);
        chk("abort_in_chal", bus.rand_ready, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("midrst");
        @(negedge clk); rst = 1'b0;
        cfg_default();
        run_proof(ea); check_end(ea, "after_rst");
        chk("after_rst_model", ea, 1'b1);

        // Randomized proofs with random defects and stalls.
        for (int it = 0; it < 8; it++) begin
            cfg_default();
            stall_cyc = $urandom_range(0, 2);
            for (int l = 0; l < NL; l++) begin
                cfg_kind[l] = $urandom_range(0, 3);
                if ($urandom_range(0, 1) == 1) cfg_force_e[l] = $urandom_range(0, 1) * 5;
            end
            if ($urandom_range(0, 3) == 0) begin
                cfg_bad_layer = $urandom_range(0, NL - 1);
                cfg_bad_round = $urandom_range(0, 2 * NB - 1);
            end
            run_proof(ea); check_end(ea, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
